video_dram_arb: RTL and testbench
=================================

Name: video_dram_arb

Overview:
- DRAM slot responder for the video fetch path. It consumes the video requester's go/address/bandwidth request and grants DRAM read slots at the programmed rate.
- It generates the video_pre_next / video_next / video_strobe handshake with read data.
- Slots not owned by video go to a single secondary (CPU/TS) requester.
- Sits between the video subsystem and the DRAM controller. One DRAM slot per 4-clock cycle, framed by the c0..c3 phase strobes.

Parameters:
- AW, 21, DRAM word address width.
- STARVE_LIM, 16, consecutive denied CPU slots that trigger the guard (optional feature only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c0, c1, c2, c3  in  1 each  one-hot slot phase strobes, cyclic c0->c1->c2->c3->c0.
- video_go  in  1  level; video wants slots while high.
- video_addr  in  AW  word address of next video read; requester advances it on video_next.
- video_bw  in  5  [2:0]+1 = video slots per window (1..8); [4:3] = window length 8<<[4:3] slots (8/16/32/64).
- video_pre_next  out  1  one-clock pulse on c1 of a video slot.
- video_next  out  1  one-clock pulse on c2 of a video slot; dram_rdata valid this clock.
- video_strobe  out  1  one-clock pulse on c3 of a video slot; video_data valid.
- video_data  out  16  dram_rdata registered at video_next; held until the next video slot.
- cpu_req  in  1  level; secondary requester wants a slot.
- cpu_addr  in  AW  secondary read address.
- cpu_next  out  1  one-clock pulse on c2 of a CPU slot.
- dram_req  out  1  high c0..c3 of any granted slot.
- dram_addr  out  AW  slot address, registered at c3, stable for the whole slot.
- dram_rdata  in  16  controller read data, valid on c2 of each slot.

Behaviour:
- Reset:
  - All outputs 0.
  - owner = IDLE, window counter = 0, go_d = 0, video_data = 0.
  - Reset mid-slot aborts the slot; no next/strobe pulses are issued for it.
- Arbitration, evaluated only on c3, applies to the following slot:
  - go_d latches video_go at every c3. A rising go (video_go=1, go_d=0) clears the window counter to 0 for that decision.
  - wcnt is a 6-bit window counter. It increments at every c3 while video_go=1 and wraps at (8<<bw[4:3])-1 back to 0. While video_go=0 it is held at 0.
  - Video is eligible when video_go=1 and wcnt < bw[2:0]+1.
  - Priority: eligible video > cpu_req > IDLE.
  - If bw[2:0]+1 >= window length, every slot goes to video.
- Slot registration at c3: owner, dram_addr (video_addr or cpu_addr), and dram_req = (owner != IDLE).
- Video slot timing:
  - video_pre_next on c1.
  - video_next on c2; video_data <= dram_rdata on c2.
  - video_strobe on c3.
- CPU slot: cpu_next on c2. No video pulses occur.
- Sampling rules:
  - video_bw changes take effect at the next c3.
  - video_addr is sampled only at c3; a change mid-slot does not alter dram_addr.
- Simultaneous events:
  - video_go falling at the same c3 as an eligible decision: no video grant (uses the sampled 0).
  - Rising go and cpu_req at the same c3: video wins (wcnt=0 is eligible).
- Address arithmetic is done by the requester; this block never increments addresses.

Optional Feature:
- Macro VIDEO_DRAM_STARVE_GUARD_EN.
- Enabled:
  - A 5-bit counter counts c3 decisions where cpu_req=1 but video won. It clears on any CPU grant or when cpu_req=0.
  - When it reaches STARVE_LIM, the next decision goes to CPU even if video is eligible. wcnt still advances, so video loses that slot.
  - The counter then clears.
- Disabled: strict video priority; the counter is absent.

Test Plan:
- Reset held then released, video_go=0, cpu_req=0 -> all outputs 0, dram_req low for 10 slots.
- video_go=1, bw=5'b00_001, addr=0x1000 -> per 8-slot window exactly 2 video slots (slots 0,1).
  - Per video slot: pre_next/next/strobe on c1/c2/c3, with dram_addr=0x1000.
  - video_data equals the dram_rdata driven at c2.
- video_go=1, bw=5'b00_111, cpu_req=1 -> all slots video, cpu_next never pulses.
- video_go=1, bw=5'b01_000, cpu_req=1 -> per 16 slots 1 video and 15 CPU slots, cpu_next on c2 with dram_addr=cpu_addr.
- video_go toggled 0->1 mid-window (wcnt=5) -> wcnt restarts at 0 and the next slot is video.
- Guard enabled, bw=5'b00_111, cpu_req=1 -> 16 video slots, then exactly 1 CPU slot, repeating. Guard disabled -> no CPU slot.

Source files
------------

// File: rtl/video_dram_arb.sv
// Video DRAM slot arbiter: grants 4-clock DRAM slots to the video fetcher at a programmed
// rate, the rest to one CPU/TS requester. Optional starvation guard: VIDEO_DRAM_STARVE_GUARD_EN.
module video_dram_arb #(
  parameter int unsigned AW         = 21,
  parameter int unsigned STARVE_LIM = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c0,
  input  logic          c1,
  input  logic          c2,
  input  logic          c3,
  input  logic          video_go,
  input  logic [AW-1:0] video_addr,
  input  logic [4:0]    video_bw,
  output logic          video_pre_next,
  output logic          video_next,
  output logic          video_strobe,
  output logic [15:0]   video_data,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_next,
  output logic          dram_req,
  output logic [AW-1:0] dram_addr,
  input  logic [15:0]   dram_rdata
);

  localparam logic [1:0] OwnIdle  = 2'd0;
  localparam logic [1:0] OwnVideo = 2'd1;
  localparam logic [1:0] OwnCpu   = 2'd2;

  logic [1:0]    owner_q, owner_d;
  logic [5:0]    wcnt_q, wcnt_d, wcnt_eff, wcnt_last;
  logic          go_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   vdata_q;
  logic [3:0]    vid_slots;
  logic          video_elig, video_win, force_cpu;

  // c0 only frames the slot; nothing is launched on it.
  logic unused_c0;
  assign unused_c0 = c0;

  assign vid_slots = {1'b0, video_bw[2:0]} + 4'd1;

  always_comb begin
    wcnt_last = 6'd7;
    unique case (video_bw[4:3])
      2'd0: wcnt_last = 6'd7;
      2'd1: wcnt_last = 6'd15;
      2'd2: wcnt_last = 6'd31;
      2'd3: wcnt_last = 6'd63;
    endcase
  end

  // A rising go restarts the window so the first decision always favours video.
  assign wcnt_eff   = (video_go && !go_q) ? 6'd0 : wcnt_q;
  assign video_elig = video_go && ({2'b00, vid_slots} > wcnt_eff);
  assign video_win  = video_elig && !force_cpu;

`ifdef VIDEO_DRAM_STARVE_GUARD_EN
  localparam logic [4:0] StarveLim = 5'(STARVE_LIM);

  logic [4:0] starve_q, starve_d;

  assign force_cpu = cpu_req && (starve_q == StarveLim);

  always_comb begin
    starve_d = starve_q;
    if (c3) begin
      starve_d = (cpu_req && video_win) ? starve_q + 5'd1 : 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_lim;
  assign unused_starve_lim = ^STARVE_LIM;
  assign force_cpu         = 1'b0;
`endif

  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    if (c3) begin
      if (video_win) begin
        owner_d = OwnVideo;
      end else if (cpu_req) begin
        owner_d = OwnCpu;
      end else begin
        owner_d = OwnIdle;
      end
      addr_d = video_win ? video_addr : cpu_addr;
      if (!video_go || (wcnt_eff == wcnt_last)) begin
        wcnt_d = '0;
      end else begin
        wcnt_d = wcnt_eff + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OwnIdle;
      wcnt_q  <= '0;
      go_q    <= 1'b0;
      addr_q  <= '0;
      vdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      if (c3) begin
        go_q <= video_go;
      end
      if (c2 && (owner_q == OwnVideo)) begin
        vdata_q <= dram_rdata;
      end
    end
  end

  assign dram_req       = (owner_q != OwnIdle);
  assign dram_addr      = addr_q;
  assign video_pre_next = c1 && (owner_q == OwnVideo);
  assign video_next     = c2 && (owner_q == OwnVideo);
  assign video_strobe   = c3 && (owner_q == OwnVideo);
  assign cpu_next       = c2 && (owner_q == OwnCpu);
  assign video_data     = vdata_q;

endmodule

// File: tb/tb_video_dram_arb.sv
// Directed bench for video_dram_arb: walks slot by slot with hand-computed owner sequences.
// Build with VIDEO_DRAM_STARVE_GUARD_EN defined to exercise the starvation guard.
module tb_video_dram_arb;

  localparam int unsigned AW = 21;

  localparam logic [1:0] OwnIdle  = 2'd0;
  localparam logic [1:0] OwnVideo = 2'd1;
  localparam logic [1:0] OwnCpu   = 2'd2;

`ifdef VIDEO_DRAM_STARVE_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          c0, c1, c2, c3;
  logic          video_go;
  logic [AW-1:0] video_addr;
  logic [4:0]    video_bw;
  logic          video_pre_next, video_next, video_strobe;
  logic [15:0]   video_data;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_next;
  logic          dram_req;
  logic [AW-1:0] dram_addr;
  logic [15:0]   dram_rdata;

  logic [1:0]    phase;
  int unsigned   n_checks;
  int unsigned   n_errors;
  int unsigned   slot_no;
  logic [15:0]   exp_vdata;

  video_dram_arb #(
    .AW         (AW),
    .STARVE_LIM (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .c0             (c0),
    .c1             (c1),
    .c2             (c2),
    .c3             (c3),
    .video_go       (video_go),
    .video_addr     (video_addr),
    .video_bw       (video_bw),
    .video_pre_next (video_pre_next),
    .video_next     (video_next),
    .video_strobe   (video_strobe),
    .video_data     (video_data),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_next       (cpu_next),
    .dram_req       (dram_req),
    .dram_addr      (dram_addr),
    .dram_rdata     (dram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase strobe source; a negedge with phase==k lies inside the cycle where ck is high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= 2'd0;
    else        phase <= phase + 2'd1;
  end
  assign c0 = (phase == 2'd0);
  assign c1 = (phase == 2'd1);
  assign c2 = (phase == 2'd2);
  assign c3 = (phase == 2'd3);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (slot %0d): got %0h, expected %0h", tag, slot_no, got, exp);
    end
  endtask

  // Entered at the phase-0 negedge of a slot, leaves at the phase-0 negedge of the next one.
  task automatic run_slot(input logic [1:0] own, input logic [AW-1:0] addr, input bit wiggle);
    logic        is_v, is_c;
    logic [15:0] rd;
    is_v = (own == OwnVideo);
    is_c = (own == OwnCpu);
    rd   = 16'hA000 + 16'(slot_no);
    check_eq("req", 64'(dram_req), 64'(own != OwnIdle));
    if (own != OwnIdle) check_eq("addr_c0", 64'(dram_addr), 64'(addr));
    check_eq("pulses_c0", 64'({video_pre_next, video_next, video_strobe, cpu_next}), 64'd0);
    check_eq("vdata_c0", 64'(video_data), 64'(exp_vdata));
    @(negedge clk);
    check_eq("pre_next", 64'({video_pre_next, video_next, video_strobe, cpu_next}),
             64'({is_v, 3'b000}));
    if (wiggle) video_addr = ~video_addr;
    dram_rdata = ~rd;
    @(negedge clk);
    check_eq("next", 64'({video_pre_next, video_next, video_strobe, cpu_next}),
             64'({1'b0, is_v, 1'b0, is_c}));
    dram_rdata = rd;
    @(negedge clk);
    if (is_v) exp_vdata = rd;
    check_eq("strobe", 64'({video_pre_next, video_next, video_strobe, cpu_next}),
             64'({2'b00, is_v, 1'b0}));
    check_eq("vdata_c3", 64'(video_data), 64'(exp_vdata));
    if (own != OwnIdle) check_eq("addr_c3", 64'(dram_addr), 64'(addr));
    if (wiggle) video_addr = ~video_addr;
    dram_rdata = ~rd;
    @(negedge clk);
    slot_no++;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    slot_no    = 0;
    exp_vdata  = 16'h0000;
    rst_n      = 1'b0;
    video_go   = 1'b0;
    video_addr = '0;
    video_bw   = 5'b00_000;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    dram_rdata = 16'h0000;

    repeat (3) @(negedge clk);
    check_eq("rst_outs", 64'({dram_req, dram_addr, video_data, video_pre_next, video_next,
                              video_strobe, cpu_next}), 64'd0);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (10) run_slot(OwnIdle, '0, 1'b0);

    // 2 of every 8 slots to video.
    video_go   = 1'b1;
    video_bw   = 5'b00_001;
    video_addr = 21'h01000;
    run_slot(OwnIdle, '0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_slot(((i % 8) < 2) ? OwnVideo : OwnIdle, 21'h01000, i == 0);
    end

    // go falls at an eligible decision: no video grant follows.
    video_go = 1'b0;
    run_slot(OwnVideo, 21'h01000, 1'b0);

    // Full-bandwidth video against a busy CPU.
    video_go = 1'b1;
    video_bw = 5'b00_111;
    cpu_req  = 1'b1;
    cpu_addr = 21'h02222;
    run_slot(OwnIdle, '0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) run_slot(OwnVideo, 21'h01000, 1'b0);
      run_slot(GuardEn ? OwnCpu : OwnVideo, GuardEn ? 21'h02222 : 21'h01000, 1'b0);
    end

    // 1 video slot per 16, CPU takes the rest.
    video_go = 1'b0;
    run_slot(OwnVideo, 21'h01000, 1'b0);
    video_go = 1'b1;
    video_bw = 5'b01_000;
    cpu_addr = 21'h03333;
    run_slot(OwnCpu, 21'h02222, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_slot((i == 0) ? OwnVideo : OwnCpu, (i == 0) ? 21'h01000 : 21'h03333, 1'b0);
    end
    run_slot(OwnVideo, 21'h01000, 1'b0);
    repeat (3) run_slot(OwnCpu, 21'h03333, 1'b0);

    // go re-asserted mid-window together with cpu_req: window restarts, video wins.
    video_go = 1'b0;
    run_slot(OwnCpu, 21'h03333, 1'b0);
    video_go = 1'b1;
    run_slot(OwnCpu, 21'h03333, 1'b0);

    // Reset in the middle of that video slot aborts it.
    check_eq("rise_req", 64'(dram_req), 64'd1);
    check_eq("rise_addr", 64'(dram_addr), 64'h01000);
    @(negedge clk);
    check_eq("rise_pre_next", 64'(video_pre_next), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid", 64'({dram_req, dram_addr, video_data, video_pre_next, video_next,
                             video_strobe, cpu_next}), 64'd0);
    video_go = 1'b0;
    cpu_req  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_hold", 64'({dram_req, video_next, video_strobe, cpu_next}), 64'd0);
    rst_n     = 1'b1;
    exp_vdata = 16'h0000;
    repeat (2) run_slot(OwnIdle, '0, 1'b0);

    // Minimum bandwidth: 1 video slot per 8.
    video_go   = 1'b1;
    video_bw   = 5'b00_000;
    video_addr = 21'h1ABCD;
    run_slot(OwnIdle, '0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      run_slot(((i % 8) == 0) ? OwnVideo : OwnIdle, 21'h1ABCD, i == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
